// File: rtl/conv3x3_window_gen.sv
// 3x3 window generator: loads one filter word for the weight buffer, then turns a raster
// pixel stream into 72-bit ifmap windows. Define STRIDE2_EN to emit only stride-2 windows.
`timescale 1ns/1ps
module conv3x3_window_gen #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        filter_valid,
    output logic        filter_ready,
    input  logic [71:0] filter_in,
    output logic [71:0] filter_out,
    output logic        wb_write_en,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [7:0]  pix_data,
    output logic        win_valid,
    input  logic        win_ready,
    output logic [71:0] ifmap,
    output logic        frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STREAM,
        ST_DONE
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          last_seen;

    // lb_prev holds row r-1, lb_prev2 holds row r-2, both indexed by column.
    logic [7:0]    lb_prev  [IMG_W];
    logic [7:0]    lb_prev2 [IMG_W];
    logic [7:0]    win      [3][3];
    logic [7:0]    win_nxt  [3][3];
    logic [71:0]   ifmap_nxt;

    logic          filter_hs;
    logic          pix_acc;
    logic          at_last;
    logic          stride_ok;
    logic          emit;
    logic          win_valid_nxt;

    assign filter_hs = filter_valid & filter_ready;
    assign pix_ready = (state == ST_STREAM) && (!win_valid || win_ready);
    assign pix_acc   = pix_valid & pix_ready;
    assign at_last   = (row == ROW_LAST) && (col == COL_LAST);

`ifdef STRIDE2_EN
    // (r-2) and (c-2) are even exactly when r and c are even.
    assign stride_ok = ~row[0] & ~col[0];
`else
    assign stride_ok = 1'b1;
`endif

    assign emit          = pix_acc && (row >= ROW_TWO) && (col >= COL_TWO) && stride_ok;
    assign win_valid_nxt = emit || (win_valid && !win_ready);

    // Window shift: columns move left, the new column comes from the line buffers and the pixel.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                win_nxt[r][c] = win[r][c];
            end
        end
        if (pix_acc) begin
            for (int r = 0; r < 3; r++) begin
                win_nxt[r][0] = win[r][1];
                win_nxt[r][1] = win[r][2];
            end
            win_nxt[0][2] = lb_prev2[col];
            win_nxt[1][2] = lb_prev[col];
            win_nxt[2][2] = pix_data;
        end
    end

    always_comb begin
        ifmap_nxt = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                ifmap_nxt[8*(3*r+c) +: 8] = win_nxt[r][c];
            end
        end
    end

    always_comb begin
        next_state  = state;
        wb_write_en = 1'b0;
        frame_done  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (filter_hs) next_state = ST_LOAD;
            end
            ST_LOAD: begin
                wb_write_en = 1'b1;
                next_state  = ST_STREAM;
            end
            ST_STREAM: begin
                // Finish only once the last pixel is in and no window is left outstanding.
                if ((last_seen || (pix_acc && at_last)) && !win_valid_nxt) next_state = ST_DONE;
            end
            ST_DONE: begin
                frame_done = 1'b1;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            filter_ready <= 1'b0;
            filter_out   <= '0;
            col          <= '0;
            row          <= '0;
            last_seen    <= 1'b0;
            win_valid    <= 1'b0;
            ifmap        <= '0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else begin
            // NOTE: state uses non-blocking assignment so every flop samples pre-edge values.
            state <= next_state;
            // Registered so it reads 0 while reset is held and 1 for the whole idle period after.
            filter_ready <= (next_state == ST_IDLE);
            if (filter_hs) filter_out <= filter_in;
            win_valid <= win_valid_nxt;
            if (emit) ifmap <= ifmap_nxt;
            if (pix_acc) begin
                win <= win_nxt;
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
            if (state != ST_STREAM) begin
                last_seen <= 1'b0;
            end else if (pix_acc && at_last) begin
                last_seen <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the line buffers are flops, so clearing them on reset is cheap and makes restarts clean.
            for (int i = 0; i < IMG_W; i++) begin
                lb_prev[i]  <= '0;
                lb_prev2[i] <= '0;
            end
        end else if (pix_acc) begin
            lb_prev2[col] <= lb_prev[col];
            lb_prev[col]  <= pix_data;
        end
    end

endmodule

// File: tb/tb_conv3x3_window_gen.sv
// Bench for conv3x3_window_gen: a frame-level model (image array + expected-window queue)
// checked every cycle, plus literal window/count expectations; honours STRIDE2_EN.
`timescale 1ns/1ps
module tb_conv3x3_window_gen;

`ifdef STRIDE2_EN
    localparam int W = 5;
    localparam int H = 5;
    localparam bit S2 = 1'b1;
    localparam logic [71:0] FIRST_LIT = 72'h0C0B0A070605020100;
    localparam logic [71:0] LAST_LIT  = 72'h1817161312110E0D0C;
`else
    localparam int W = 4;
    localparam int H = 4;
    localparam bit S2 = 1'b0;
    localparam logic [71:0] FIRST_LIT = 72'h0A0908060504020100;
    localparam logic [71:0] LAST_LIT  = 72'h0F0E0D0B0A09070605;
`endif
    localparam int EXP_WINS = 4;
    localparam logic [71:0] F1 = 72'h090807060504030201;
    localparam logic [71:0] F2 = 72'hA5_5A_C3_3C_0F_F0_81_7E_11;
    localparam logic [71:0] F3 = 72'h123456789ABCDEF012;

    logic        clk, rst;
    logic        filter_valid, filter_ready;
    logic [71:0] filter_in, filter_out;
    logic        wb_write_en;
    logic        pix_valid, pix_ready;
    logic [7:0]  pix_data;
    logic        win_valid, win_ready;
    logic [71:0] ifmap;
    logic        frame_done;

    conv3x3_window_gen #(.IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst(rst),
        .filter_valid(filter_valid), .filter_ready(filter_ready),
        .filter_in(filter_in), .filter_out(filter_out), .wb_write_en(wb_write_en),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .win_valid(win_valid), .win_ready(win_ready), .ifmap(ifmap),
        .frame_done(frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    typedef enum int {P_IDLE, P_LOAD, P_STREAM, P_DONE} phase_t;

    bit          mon_en = 1'b0;
    phase_t      phase;
    logic [7:0]  img [H][W];
    logic [71:0] exp_q[$];
    logic [71:0] win_log[$];
    logic [71:0] exp_filter;
    int          mr, mc;
    bit          all_in;
    int          wb_cnt = 0;
    int          wr_mode = 0;
    int          stall_cnt = 0;

    function automatic logic [71:0] model_window(input int r0, input int c0);
        logic [71:0] w;
        w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[8*(3*i+j) +: 8] = img[r0+i][c0+j];
        return w;
    endfunction

    // Compare process: outputs sampled on the falling edge, model advanced by the handshakes seen there.
    initial begin
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                phase = P_IDLE;
                exp_q.delete();
                mr = 0;
                mc = 0;
                all_in = 1'b0;
                exp_filter = '0;
            end else begin
                check("filter_ready", 72'(filter_ready), 72'(phase == P_IDLE));
                check("wb_write_en", 72'(wb_write_en), 72'(phase == P_LOAD));
                check("frame_done", 72'(frame_done), 72'(phase == P_DONE));
                check("filter_out", filter_out, exp_filter);
                check("pix_ready", 72'(pix_ready),
                      72'((phase == P_STREAM) && (exp_q.size() == 0 || win_ready)));
                check("win_valid", 72'(win_valid), 72'(exp_q.size() != 0));
                if (exp_q.size() != 0) check("ifmap", ifmap, exp_q[0]);
                if (wb_write_en) wb_cnt++;
                case (phase)
                    P_IDLE: begin
                        if (filter_valid && filter_ready) begin
                            exp_filter = filter_in;
                            phase = P_LOAD;
                        end
                    end
                    P_LOAD: phase = P_STREAM;
                    P_DONE: phase = P_IDLE;
                    default: begin
                        if (win_valid && win_ready && exp_q.size() != 0) begin
                            win_log.push_back(ifmap);
                            void'(exp_q.pop_front());
                        end
                        if (pix_valid && pix_ready) begin
                            img[mr][mc] = pix_data;
                            if (mr >= 2 && mc >= 2 && (!S2 || ((mr - 2) % 2 == 0 && (mc - 2) % 2 == 0)))
                                exp_q.push_back(model_window(mr - 2, mc - 2));
                            if (mr == H - 1 && mc == W - 1) all_in = 1'b1;
                            mc++;
                            if (mc == W) begin
                                mc = 0;
                                mr = (mr == H - 1) ? 0 : mr + 1;
                            end
                        end
                        if (all_in && exp_q.size() == 0) begin
                            all_in = 1'b0;
                            phase = P_DONE;
                        end
                    end
                endcase
            end
        end
    end

    // Consumer: mode 0 always ready, mode 1 stalls the first window for 5 cycles, mode 2 random.
    initial begin
        win_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (wr_mode)
                1: begin
                    if (stall_cnt < 5) begin
                        win_ready = 1'b0;
                        if (win_valid) stall_cnt++;
                    end else begin
                        win_ready = 1'b1;
                    end
                end
                2: win_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    win_ready = 1'b1;
                    stall_cnt = 0;
                end
            endcase
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_filter_ready"}, 72'(filter_ready), 72'(0));
        check({tag, "_filter_out"}, filter_out, 72'(0));
        check({tag, "_wb_write_en"}, 72'(wb_write_en), 72'(0));
        check({tag, "_pix_ready"}, 72'(pix_ready), 72'(0));
        check({tag, "_win_valid"}, 72'(win_valid), 72'(0));
        check({tag, "_ifmap"}, ifmap, 72'(0));
        check({tag, "_frame_done"}, 72'(frame_done), 72'(0));
    endtask

    // Called one time unit after a rising edge; returns one time unit after the handshake edge.
    task automatic load_filter(input logic [71:0] f);
        int n;
        filter_in = f;
        filter_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!filter_ready && n < 50);
        if (!filter_ready) check("filter_handshake_timeout", 72'(filter_ready), 72'(1));
        @(posedge clk);
        #1;
        filter_valid = 1'b0;
    endtask

    task automatic send_pixel(input logic [7:0] d, input bit gaps);
        int n;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                pix_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        pix_valid = 1'b1;
        pix_data = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!pix_ready && n < 200);
        if (!pix_ready) check("pixel_accept_timeout", 72'(pix_ready), 72'(1));
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
    endtask

    task automatic run_frame(input logic [71:0] f, input int mode);
        int base, wb0, n;
        wr_mode = mode;
        base = win_log.size();
        wb0 = wb_cnt;
        load_filter(f);
        for (int k = 0; k < W * H; k++) send_pixel(8'(k), mode == 2);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 100);
        check("frame_done_seen", 72'(frame_done), 72'(1));
        @(posedge clk);
        #1;
        check("win_count", 72'(win_log.size() - base), 72'(EXP_WINS));
        if (win_log.size() > base) begin
            check("first_window", win_log[base], FIRST_LIT);
            check("last_window", win_log[win_log.size() - 1], LAST_LIT);
        end
        check("wb_pulses", 72'(wb_cnt - wb0), 72'(1));
        check("filter_hold", filter_out, f);
        if (mode == 1) check("stall_cycles", 72'(stall_cnt), 72'(5));
    endtask

    initial begin
        rst = 1'b0;
        filter_valid = 1'b0;
        filter_in = '0;
        pix_valid = 1'b0;
        pix_data = '0;
        #12;
        check_all_zero("por");
        @(posedge clk);
        #3 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 mon_en = 1'b1;

        // Asynchronous reset in the middle of a frame.
        load_filter(F1);
        for (int k = 0; k < 6; k++) send_pixel(8'(k), 1'b0);
        mon_en = 1'b0;
        pix_valid = 1'b1;
        pix_data = 8'hFF;
        #2 rst = 1'b0;
        #1 check_all_zero("midrst");
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        pix_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 mon_en = 1'b1;

        run_frame(F1, 0);
        run_frame(F2, 1);
        run_frame(F3, 2);
        wr_mode = 0;
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
